// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - sequential two's-complement shift/add multiplier on a ripple-carry adder

module ripple_adder #(
    parameter int N = 9
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_cin,
    output logic [N-1:0] o_sum
);
    // The carry out of the top bit is never needed, so the chain stops at bit N-1.
    logic [N-1:0] w_c;

    assign w_c[0] = i_cin;

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign o_sum[i] = i_a[i] ^ i_b[i] ^ w_c[i];
        if (i < N - 1) begin : g_carry
            assign w_c[i+1] = (i_a[i] & i_b[i]) | (i_a[i] & w_c[i]) | (i_b[i] & w_c[i]);
        end
    end
endmodule

module shift_add_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic             ClearA_LoadB,
    input  logic [WIDTH-1:0] S,
    output logic [WIDTH-1:0] Aval,
    output logic [WIDTH-1:0] Bval,
    output logic             Xval,
    output logic             Done
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {IDLE, CLR, ADD, SHIFT, DONE} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_m;
    logic             r_x;
    logic [CW-1:0]    r_cnt;

    logic             w_last;
    logic [WIDTH:0]   w_aext;
    logic [WIDTH:0]   w_mext;
    logic [WIDTH:0]   w_addb;
    logic [WIDTH:0]   w_sum;

    // The final multiplier bit carries negative weight, so that step subtracts M.
    assign w_last = (r_cnt == LAST);
    assign w_aext = {r_a[WIDTH-1], r_a};
    assign w_mext = {r_m[WIDTH-1], r_m};
    assign w_addb = w_last ? ~w_mext : w_mext;

    ripple_adder #(.N(WIDTH + 1)) u_adder (
        .i_a   (w_aext),
        .i_b   (w_addb),
        .i_cin (w_last),
        .o_sum (w_sum)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (Run) w_next = CLR;
            CLR:     w_next = ADD;
            ADD:     w_next = SHIFT;
            SHIFT:   w_next = w_last ? DONE : ADD;
            DONE:    if (!Run) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_a   <= '0;
            r_b   <= '0;
            r_m   <= '0;
            r_x   <= 1'b0;
            r_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!Run && ClearA_LoadB) begin
                        r_a <= '0;
                        r_x <= 1'b0;
                        r_b <= S;
                    end
                end
                CLR: begin
                    r_a   <= '0;
                    r_x   <= 1'b0;
                    r_m   <= S;
                    r_cnt <= '0;
                end
                ADD: begin
                    if (r_b[0]) begin
                        {r_x, r_a} <= w_sum;
                    end
                end
                SHIFT: begin
                    r_a <= {r_x, r_a[WIDTH-1:1]};
                    r_b <= {r_a[0], r_b[WIDTH-1:1]};
                    if (!w_last) r_cnt <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign Aval = r_a;
    assign Bval = r_b;
    assign Xval = r_x;
    assign Done = (r_state == DONE);
endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb/tb_shift_add_multiplier.sv - directed scoreboard bench for shift_add_multiplier

module tb_shift_add_multiplier;
    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Run = 1'b0;
    logic       ClearA_LoadB = 1'b0;
    logic [7:0] S = 8'h00;
    logic [7:0] Aval;
    logic [7:0] Bval;
    logic       Xval;
    logic       Done;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       x;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] b_model = 8'h00;
    int         checks = 0;
    int         passed = 0;

    shift_add_multiplier #(.WIDTH(8)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Run          (Run),
        .ClearA_LoadB (ClearA_LoadB),
        .S            (S),
        .Aval         (Aval),
        .Bval         (Bval),
        .Xval         (Xval),
        .Done         (Done)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic load(input logic [7:0] s);
        S = s;
        ClearA_LoadB = 1'b1;
        step();
        ClearA_LoadB = 1'b0;
        b_model = s;
        check("load_a", {8'h00, Aval}, 16'h0000);
        check("load_b", {8'h00, Bval}, {8'h00, s});
        check("load_x", {15'h0, Xval}, 16'h0000);
    endtask

    task automatic run_op(input logic [7:0] s, input int hold, input bit disturb);
        logic [15:0] p;
        exp_t        e;
        int          n;
        p = $signed({{8{b_model[7]}}, b_model}) * $signed({{8{s[7]}}, s});
        sb.push_back('{a: p[15:8], b: p[7:0], x: p[15]});
        b_model = p[7:0];
        S = s;
        Run = 1'b1;
        step();
        n = 0;
        while (!Done && n < 100) begin
            if (disturb && n == 5) begin
                S = ~s;
                ClearA_LoadB = 1'b1;
            end
            if (disturb && n == 9) ClearA_LoadB = 1'b0;
            step();
            n++;
        end
        check("done_latency", 16'(n), 16'd17);
        if (sb.size() == 0) begin
            check("sb_empty", 16'h0001, 16'h0000);
        end else begin
            e = sb.pop_front();
            check("prod_a", {8'h00, Aval}, {8'h00, e.a});
            check("prod_b", {8'h00, Bval}, {8'h00, e.b});
            check("prod_x", {15'h0, Xval}, {15'h0, e.x});
            for (int i = 0; i < hold; i++) begin
                step();
                check("done_held", {15'h0, Done}, 16'h0001);
            end
            if (hold > 0) check("hold_result", {Aval, Bval}, {e.a, e.b});
        end
        Run = 1'b0;
        step();
        check("done_clear", {15'h0, Done}, 16'h0000);
    endtask

    initial begin
        step();
        step();
        check("rst_a", {8'h00, Aval}, 16'h0000);
        check("rst_b", {8'h00, Bval}, 16'h0000);
        check("rst_x", {15'h0, Xval}, 16'h0000);
        check("rst_done", {15'h0, Done}, 16'h0000);
        Reset = 1'b0;
        step();

        load(8'h07);
        run_op(8'hFD, 0, 1'b0);
        check("tp_neg21", {Aval, Bval}, 16'hFFEB);
        run_op(8'hFD, 0, 1'b0);
        check("tp_pos63", {Aval, Bval}, 16'h003F);

        load(8'h80);
        run_op(8'h80, 0, 1'b0);
        check("tp_minmin", {Aval, Bval}, 16'h4000);
        load(8'h00);
        run_op(8'h5A, 0, 1'b0);
        load(8'hFF);
        run_op(8'h01, 0, 1'b0);
        check("tp_minus1", {Aval, Bval}, 16'hFFFF);

        load(8'h07);
        S = 8'h03;
        Run = 1'b1;
        step();
        repeat (8) step();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        Run = 1'b0;
        check("abort_ab", {Aval, Bval}, 16'h0000);
        check("abort_x", {15'h0, Xval}, 16'h0000);
        check("abort_done", {15'h0, Done}, 16'h0000);
        b_model = 8'h00;
        step();
        check("abort_idle", {Aval, Bval, 7'h0, Done}, 23'h0);
        load(8'h07);
        run_op(8'h03, 0, 1'b0);
        check("after_abort", {Aval, Bval}, 16'h0015);

        load(8'h0B);
        run_op(8'hF9, 10, 1'b1);
        check("hold_prod", {Aval, Bval}, 16'hFFB3);
        check("hold_sb_empty", 16'(sb.size()), 16'h0000);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
